// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, registered carry, LSB first.
// Ports: clk, rst (sync, high), start/a/b/c_in in; busy/done/sum/carry/ovf out.
// SERIAL_ADDER_OVF_EN enables the signed-overflow flag; otherwise ovf is 0.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             cy;
  logic [CW-1:0]    cnt;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] s_nxt;
  logic             load;
  logic             last;

  assign fa_s  = a_sh[0] ^ b_sh[0] ^ cy;
  assign fa_c  = (a_sh[0] & b_sh[0]) |
                 (a_sh[0] & cy) |
                 (b_sh[0] & cy);
  assign s_nxt = {fa_s, s_sh[WIDTH-1:1]};

  // start is honoured in IDLE and DONE, never mid-operation
  assign load = start && (state != RUN);
  assign last = (state == RUN) &&
                (cnt == CW'(WIDTH - 1));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      cy    <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      carry <= 1'b0;
    end else if (load) begin
      state <= RUN;
      a_sh  <= a;
      b_sh  <= b;
      s_sh  <= '0;
      cy    <= c_in;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          s_sh <= s_nxt;
          cy   <= fa_c;
          cnt  <= cnt + 1'b1;
          if (last) begin
            sum   <= s_nxt;
            carry <= fa_c;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // cy is the carry into the MSB while the MSB is processed
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (last) begin
      ovf <= cy ^ fa_c;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8).
// Vector table plus hand-written multi-cycle sequences.
module tb_serial_adder;

  localparam int W = 8;
`ifdef SERIAL_ADDER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;
  logic         ovf;

  int n_chk  = 0;
  int n_fail = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       c;
    logic       v;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one op; returns edges from accept to done and the busy-gap count.
  task automatic run_op(input logic [7:0] va,
                        input logic [7:0] vb,
                        input logic vci,
                        output int lat,
                        output int gaps);
    @(negedge clk);
    a = va; b = vb; c_in = vci; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    lat  = 0;
    gaps = 0;
    while (!done && lat < 40) begin
      if (!busy) gaps++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  int lat, gaps, ndone, t1, t2, idle_gap;
  logic [7:0] s_first;
  logic       c_first;

  initial begin
    vt[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vt[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
    vt[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vt[8] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].ci, lat, gaps);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(W));
      chk($sformatf("v%0d_busy_gap", i), 32'(gaps), 32'd0);
      chk($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
      chk($sformatf("v%0d_sum", i), 32'(sum), 32'(vt[i].s));
      chk($sformatf("v%0d_carry", i), 32'(carry), 32'(vt[i].c));
      chk($sformatf("v%0d_ovf", i), 32'(ovf),
          32'(vt[i].v & OVF_EN));
      @(negedge clk);
      chk($sformatf("v%0d_done_width", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_sum_hold", i), 32'(sum), 32'(vt[i].s));
    end

    // start pulses mid-RUN must be ignored
    @(negedge clk);
    a = 8'h10; b = 8'h20; c_in = 1'b0; start = 1'b1;
    ndone = 0; s_first = '0; c_first = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        s_first = sum;
        c_first = carry;
      end
      start = (i == 3 || i == 5);
      a = 8'hAA; b = 8'h55;
    end
    chk("ign_ndone", 32'(ndone), 32'd1);
    chk("ign_sum", 32'(s_first), 32'h30);
    chk("ign_carry", 32'(c_first), 32'd0);

    // back-to-back with start held high
    @(negedge clk);
    a = 8'h01; b = 8'h01; c_in = 1'b0; start = 1'b1;
    ndone = 0; t1 = 0; t2 = 0; idle_gap = 0;
    for (int i = 1; i <= 40 && ndone < 2; i++) begin
      @(negedge clk);
      if (busy && done) chk("b2b_busy_done", 32'd1, 32'd0);
      if (!busy && !done) idle_gap++;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          t1 = i;
          chk("b2b_sum1", 32'(sum), 32'h02);
          a = 8'h02; b = 8'h02;
        end else begin
          t2 = i;
          chk("b2b_sum2", 32'(sum), 32'h04);
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("b2b_ndone", 32'(ndone), 32'd2);
    chk("b2b_spacing", 32'(t2 - t1), 32'(W + 1));
    chk("b2b_idle_gap", 32'(idle_gap), 32'd0);

    // reset in the middle of an operation
    run_op(8'h03, 8'h04, 1'b0, lat, gaps);
    chk("pre_rst_sum", 32'(sum), 32'h07);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_sum", 32'(sum), 32'd0);
    chk("mrst_carry", 32'(carry), 32'd0);
    chk("mrst_ovf", 32'(ovf), 32'd0);
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("mrst_no_done", 32'(ndone), 32'd0);
    chk("mrst_sum_hold", 32'(sum), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
